// File: rtl/clock_pkg.sv
// Shared types, BCD limits and the BCD increment helper for the alarm clock controller.
package clock_pkg;

   typedef enum logic [2:0] {
      RUN          = 3'd0,
      SET_HOUR     = 3'd1,
      SET_MIN      = 3'd2,
      SET_ALM_HOUR = 3'd3,
      SET_ALM_MIN  = 3'd4
   } mode_t;

   localparam logic [7:0] SEC_MAX  = 8'h59;
   localparam logic [7:0] MIN_MAX  = 8'h59;
   localparam logic [7:0] HOUR_MAX = 8'h23;

   // Wide enough for the largest ring timeout (255) and snooze interval (1023).
   localparam int TICK_W = 10;

   // Next BCD value with wrap at max; a low nibble of 9 or above always carries
   // so a corrupted digit can never persist.
   function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] max);
      if (v == max)
         return 8'h00;
      else if (v[3:0] >= 4'd9)
         return {v[7:4] + 4'd1, 4'h0};
      else
         return v + 8'd1;
   endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD counter that wraps at MAX; carry is high in the cycle an inc wraps it.
module bcd_wrap_counter
   import clock_pkg::*;
#(
   parameter logic [7:0] MAX = 8'h59
) (
   input  logic       clkin,
   input  logic       reset_n,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] value,
   output logic       carry
);

   assign carry = inc && (value == MAX);

   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n)
         value <= 8'h00;
      else if (clr)
         value <= 8'h00;
      else if (inc)
         value <= bcd_next(value, MAX);
   end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Time-keeping, set-mode FSM and alarm ring control for the alarm clock.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_clock_ctrl
   import clock_pkg::*;
#(
   parameter int RING_TIMEOUT = 60,
   parameter int SNOOZE_TICKS = 300
) (
   input  logic       clkin,
   input  logic       reset_n,
   input  logic       tick_1hz,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_stop,
   input  logic       btn_snooze,
   input  logic       alarm_en,
   output logic [7:0] sec,
   output logic [7:0] min,
   output logic [7:0] hour,
   output logic [7:0] alm_min,
   output logic [7:0] alm_hour,
   output logic [2:0] mode,
   output logic       ring
);

   localparam logic [TICK_W-1:0] RING_LAST = TICK_W'(RING_TIMEOUT - 1);

   mode_t             mode_r;
   logic              tick_q;
   logic [TICK_W-1:0] ring_cnt;
   logic              time_run, mode_ev, inc_ev, match;
   logic              sec_c, min_c, hour_c, amin_c, ahour_c;
   logic              unused_carry;

   // Buttons are single-cycle pulses: each acts once, on the edge that samples it.
   assign time_run = tick_1hz && (mode_r == RUN || mode_r == SET_ALM_HOUR || mode_r == SET_ALM_MIN);
   assign mode_ev  = btn_mode && !ring;
   assign inc_ev   = btn_inc && !btn_mode && !ring;
   assign match    = tick_q && alarm_en && (sec == 8'h00) && (min == alm_min) && (hour == alm_hour);
   assign mode     = mode_r;
   assign unused_carry = hour_c | amin_c | ahour_c;

   bcd_wrap_counter #(.MAX(SEC_MAX)) u_sec (
      .clkin(clkin), .reset_n(reset_n), .inc(time_run),
      .clr(mode_ev && mode_r == SET_MIN), .value(sec), .carry(sec_c));

   bcd_wrap_counter #(.MAX(MIN_MAX)) u_min (
      .clkin(clkin), .reset_n(reset_n),
      .inc(sec_c || (inc_ev && mode_r == SET_MIN)),
      .clr(1'b0), .value(min), .carry(min_c));

   // Manual minute wraps must not ripple into the hour, so only running carries pass.
   bcd_wrap_counter #(.MAX(HOUR_MAX)) u_hour (
      .clkin(clkin), .reset_n(reset_n),
      .inc((min_c && time_run) || (inc_ev && mode_r == SET_HOUR)),
      .clr(1'b0), .value(hour), .carry(hour_c));

   bcd_wrap_counter #(.MAX(MIN_MAX)) u_alm_min (
      .clkin(clkin), .reset_n(reset_n), .inc(inc_ev && mode_r == SET_ALM_MIN),
      .clr(1'b0), .value(alm_min), .carry(amin_c));

   bcd_wrap_counter #(.MAX(HOUR_MAX)) u_alm_hour (
      .clkin(clkin), .reset_n(reset_n), .inc(inc_ev && mode_r == SET_ALM_HOUR),
      .clr(1'b0), .value(alm_hour), .carry(ahour_c));

   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n)
         mode_r <= RUN;
      else begin
         case (mode_r)
            RUN:          if (mode_ev) mode_r <= SET_HOUR;
            SET_HOUR:     if (mode_ev) mode_r <= SET_MIN;
            SET_MIN:      if (mode_ev) mode_r <= SET_ALM_HOUR;
            SET_ALM_HOUR: if (mode_ev) mode_r <= SET_ALM_MIN;
            SET_ALM_MIN:  if (mode_ev) mode_r <= RUN;
            default:      mode_r <= RUN;
         endcase
      end
   end

`ifdef ALARM_SNOOZE_EN
   localparam logic [TICK_W-1:0] SNOOZE_LOAD = TICK_W'(SNOOZE_TICKS);
   logic              snz_pend;
   logic [TICK_W-1:0] snz_cnt;
`else
   logic unused_snooze;
   assign unused_snooze = btn_snooze | (SNOOZE_TICKS == 0);
`endif

   // tick_q marks that the visible time was just advanced by a RUN tick; the
   // alarm compare uses it so only tick-driven arrivals can ring.
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         ring     <= 1'b0;
         tick_q   <= 1'b0;
         ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
         snz_pend <= 1'b0;
         snz_cnt  <= '0;
`endif
      end else begin
         tick_q <= tick_1hz && (mode_r == RUN);
         if (ring) begin
            if (!alarm_en || btn_stop) begin
               ring     <= 1'b0;
               ring_cnt <= '0;
            end
`ifdef ALARM_SNOOZE_EN
            else if (btn_snooze) begin
               ring     <= 1'b0;
               ring_cnt <= '0;
               snz_pend <= 1'b1;
               snz_cnt  <= SNOOZE_LOAD;
            end
`endif
            else if (tick_1hz) begin
               if (ring_cnt == RING_LAST) begin
                  ring     <= 1'b0;
                  ring_cnt <= '0;
               end else
                  ring_cnt <= ring_cnt + TICK_W'(1);
            end
         end else if (match) begin
            ring     <= 1'b1;
            ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
            snz_pend <= 1'b0;
`endif
         end
`ifdef ALARM_SNOOZE_EN
         else if (snz_pend) begin
            if (!alarm_en || btn_stop) begin
               snz_pend <= 1'b0;
               snz_cnt  <= '0;
            end else if (snz_cnt == '0) begin
               ring     <= 1'b1;
               ring_cnt <= '0;
               snz_pend <= 1'b0;
            end else if (tick_1hz)
               snz_cnt <= snz_cnt - TICK_W'(1);
         end
`endif
      end
   end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// Scoreboarded bench for alarm_clock_ctrl: a seconds-of-day reference model feeds
// an expected queue that a monitor checks every cycle.
module tb_alarm_clock_ctrl;

   localparam int RT  = 60;
   localparam int SNZ = 5;
   localparam int W   = 44;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNOOZE_ON = 1'b1;
`else
   localparam bit SNOOZE_ON = 1'b0;
`endif

   logic clkin = 1'b0;
   logic reset_n = 1'b0;
   logic tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
   logic btn_stop = 1'b0, btn_snooze = 1'b0, alarm_en = 1'b0;
   logic [7:0] sec, min, hour, alm_min, alm_hour;
   logic [2:0] mode;
   logic       ring;

   always #5 clkin = ~clkin;

   alarm_clock_ctrl #(.RING_TIMEOUT(RT), .SNOOZE_TICKS(SNZ)) dut (
      .clkin(clkin), .reset_n(reset_n), .tick_1hz(tick_1hz),
      .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_stop(btn_stop),
      .btn_snooze(btn_snooze), .alarm_en(alarm_en),
      .sec(sec), .min(min), .hour(hour), .alm_min(alm_min),
      .alm_hour(alm_hour), .mode(mode), .ring(ring));

   logic [W-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit en_lvl = 1'b0;

   // Reference model: time as seconds of day, alarm as plain integers.
   int m_t, m_ah, m_am, m_md, m_rcnt, m_scnt;
   bit m_ring, m_tp, m_spend;

   function automatic logic [7:0] bcd(input int n);
      return 8'(((n / 10) << 4) | (n % 10));
   endfunction

   function automatic logic [W-1:0] expected();
      return {bcd(m_t % 60), bcd((m_t / 60) % 60), bcd(m_t / 3600),
              bcd(m_am), bcd(m_ah), 3'(m_md), m_ring};
   endfunction

   task automatic model_reset();
      m_t = 0; m_ah = 0; m_am = 0; m_md = 0; m_rcnt = 0; m_scnt = 0;
      m_ring = 0; m_tp = 0; m_spend = 0;
   endtask

   task automatic model_step(input bit tk, input bit bm, input bit bi,
                             input bit bs, input bit bz, input bit en);
      int h, m, s;
      bit run, mev, iev, hit;
      h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
      mev = bm && !m_ring;
      iev = bi && !bm && !m_ring;
      run = tk && (m_md == 0 || m_md == 3 || m_md == 4);
      hit = m_tp && en && (m_t == m_ah * 3600 + m_am * 60);
      m_tp = tk && (m_md == 0);
      if (iev) begin
         case (m_md)
            1: h = (h + 1) % 24;
            2: m = (m + 1) % 60;
            3: m_ah = (m_ah + 1) % 24;
            4: m_am = (m_am + 1) % 60;
            default: ;
         endcase
      end
      if (mev && m_md == 2) s = 0;
      m_t = h * 3600 + m * 60 + s;
      if (run) m_t = (m_t + 1) % 86400;
      if (mev) m_md = (m_md + 1) % 5;
      if (m_ring) begin
         if (!en || bs) m_ring = 0;
         else if (SNOOZE_ON && bz) begin
            m_ring = 0; m_spend = 1; m_scnt = SNZ;
         end else if (tk) begin
            m_rcnt++;
            if (m_rcnt == RT) m_ring = 0;
         end
      end else if (hit) begin
         m_ring = 1; m_rcnt = 0; m_spend = 0;
      end else if (m_spend) begin
         if (!en || bs) m_spend = 0;
         else if (m_scnt == 0) begin
            m_ring = 1; m_rcnt = 0; m_spend = 0;
         end else if (tk) m_scnt--;
      end
   endtask

   task automatic step(input bit tk, input bit bm, input bit bi, input bit bs, input bit bz);
      @(negedge clkin);
      reset_n = 1'b1;
      tick_1hz = tk; btn_mode = bm; btn_inc = bi; btn_stop = bs; btn_snooze = bz;
      alarm_en = en_lvl;
      model_step(tk, bm, bi, bs, bz, en_lvl);
      exp_q.push_back(expected());
      cyc++;
   endtask

   task automatic idles(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clkin);
         reset_n = 1'b0;
         tick_1hz = 0; btn_mode = 0; btn_inc = 0; btn_stop = 0; btn_snooze = 0;
         alarm_en = en_lvl;
         model_reset();
         exp_q.push_back(expected());
         cyc++;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(1, 0, 0, 0, 0);
         idles($urandom_range(0, 2));
      end
   endtask

   task automatic press_mode(input int n);
      for (int i = 0; i < n; i++) begin
         step(0, 1, 0, 0, 0);
         idles($urandom_range(0, 1));
      end
   endtask

   task automatic press_inc(input int n);
      for (int i = 0; i < n; i++) begin
         step(0, 0, 1, 0, 0);
         idles($urandom_range(0, 1));
      end
   endtask

   task automatic tick_until_ring(input int maxt);
      int k;
      k = 0;
      while (!m_ring && k < maxt) begin
         step(1, 0, 0, 0, 0);
         idles(2);
         k++;
      end
      checks++;
      if (!m_ring) begin
         errors++;
         $display("FAIL ring_wait: no ring after %0d ticks, required ring within bound", k);
      end
   endtask

   // Walks the set modes from RUN and arms the alarm for the minute after the current one.
   task automatic set_alarm_next_min();
      int tgt, th, tm;
      tgt = (m_t / 60 + 1) % 1440;
      th = tgt / 60; tm = tgt % 60;
      press_mode(3);
      press_inc((th - m_ah + 24) % 24);
      press_mode(1);
      press_inc((tm - m_am + 60) % 60);
      press_mode(1);
   endtask

   initial begin : monitor
      logic [W-1:0] exp, got;
      forever begin
         @(posedge clkin);
         #1;
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {sec, min, hour, alm_min, alm_hour, mode, ring};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL out_check t=%0t got hh:mm:ss=%h:%h:%h alm=%h:%h mode=%0d ring=%b required %h:%h:%h alm=%h:%h mode=%0d ring=%b",
                        $time, hour, min, sec, alm_hour, alm_min, mode, ring,
                        exp[27:20], exp[35:28], exp[43:36], exp[11:4], exp[19:12], exp[3:1], exp[0]);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      model_reset();
      en_lvl = 0;
      do_reset(3);
      idles(2);

      // Sixty seconds from reset: 00:00:00 .. 00:00:59 then 00:01:00.
      ticks(60);

      // Set 23:59 by hand, run to 23:59:58 then through midnight.
      press_mode(1);
      press_inc(23);
      press_mode(1);
      press_inc((59 - (m_t / 60) % 60 + 60) % 60);
      press_mode(3);
      ticks(58);
      ticks(2);

      // Hour set with wrap, ticks ignored, mode+inc together drops inc.
      press_mode(1);
      for (int i = 0; i < 25; i++) begin
         step($urandom_range(0, 1), 0, 1, 0, 0);
         step(1, 0, 0, 0, 0);
      end
      step(0, 1, 1, 0, 0);
      press_mode(3);
      ticks(3);

      // Reset in the middle of a set mode, then alarm at 00:02.
      press_mode(1);
      do_reset(2);
      press_mode(4);
      press_inc(2);
      press_mode(1);
      en_lvl = 1;
      tick_until_ring(200);
      idles(3);
      step(0, 0, 0, 1, 0);
      idles(3);

      // Unattended ring times out; mode/inc presses during ring are ignored.
      set_alarm_next_min();
      tick_until_ring(100);
      step(0, 1, 1, 0, 0);
      ticks(RT + 2);

      // Dropping alarm_en silences the ring.
      set_alarm_next_min();
      tick_until_ring(100);
      idles(2);
      en_lvl = 0;
      idles(3);
      en_lvl = 1;

      // Snooze press during ring (acts only when snooze is built in).
      set_alarm_next_min();
      tick_until_ring(100);
      step(0, 0, 0, 0, 1);
      idles(2);
`ifdef ALARM_SNOOZE_EN
      tick_until_ring(SNZ + 3);
      step(0, 0, 0, 1, 1);
      ticks(SNZ + 4);
`else
      ticks(3);
      step(0, 0, 0, 1, 0);
      idles(2);
`endif

      // Random traffic with an alarm armed just ahead.
      set_alarm_next_min();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) en_lvl = ~en_lvl;
         step($urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 19) == 0);
      end
      idles(3);

      @(negedge clkin);
      @(negedge clkin);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
